// File: rtl/core_pkg.sv
// Shared encodings for the memory pipeline stage: result-source selects,
// load/store size codes and the bus-access state type.
package core_pkg;

    // Writeback result source selects
    localparam logic [1:0] ALU_RESULT = 2'b00;
    localparam logic [1:0] MEM_TO_REG = 2'b01;
    localparam logic [1:0] PC_PLUS    = 2'b10;
    localparam logic [1:0] LUI_AUIPC  = 2'b11;

    // funct3 access size / signedness encodings
    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    // Bus access state
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for data-memory accesses: byte enables, replicated
// store data, shifted and extended load data, and the alignment check.
module lsu_align
    import core_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [31:0]        shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    // Store side: lane enables, replicated write data, alignment by size
    always_comb begin
        be         = 4'b1111;
        wdata      = store_data;
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'(4'b0001 << addr_lo);
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be         = 4'(4'b0011 << addr_lo);
                wdata      = {2{store_data[15:0]}};
                misaligned = addr_lo[0];
            end
            default: begin
                // 10 and the unused 11 encoding both behave as a word access
                be         = 4'b1111;
                wdata      = store_data;
                misaligned = |addr_lo;
            end
        endcase
    end

    // Load side: move the addressed lane to bit 0, then extend by funct3
    always_comb begin
        shifted   = rdata >> {addr_lo, 3'b000};
        byte_s    = shifted[7:0];
        half_s    = shifted[15:0];
        load_data = shifted;
        case (funct3)
            LS_B:    load_data = 32'(byte_s);
            LS_BU:   load_data = {24'h0, shifted[7:0]};
            LS_H:    load_data = 32'(half_s);
            LS_HU:   load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/stage_memory.sv
// Memory pipeline stage: issues loads/stores over a req/ack bus, stalls
// upstream while an access is outstanding, aborts on timeout and registers
// the mem_* signals used for forwarding and writeback.
module stage_memory
    import core_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       execute_alu_result,
    input  logic [31:0]       execute_wr_datamem_data,
    input  logic [2:0]        execute_funct3,
    input  logic              execute_datamem_wr_enable,
    input  logic [1:0]        execute_result_src,
    input  logic [4:0]        execute_rd,
    input  logic              execute_regfile_wr_enable,
    input  logic [31:0]       execute_instr_addr_plus,
    output logic              mem_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic [4:0]        mem_rd,
    output logic              mem_regfile_wr_enable,
    output logic [1:0]        mem_result_src,
    output logic [31:0]       mem_alu_result,
    output logic [31:0]       mem_read_data,
    output logic [31:0]       mem_instr_addr_plus,
    output logic              mem_misaligned,
    output logic              mem_bus_error
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT_CYCLES);

    mem_state_t  state;
    logic [15:0] counter;

    logic        is_store;
    logic        is_load;
    logic        is_mem;
    logic        misaligned;
    logic        aligned_op;
    logic        timeout_hit;
    logic        acked;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] load_ext;

    lsu_align u_align (
        .addr_lo    (execute_alu_result[1:0]),
        .funct3     (execute_funct3),
        .store_data (execute_wr_datamem_data),
        .rdata      (dmem_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (load_ext),
        .misaligned (misaligned)
    );

    // Access classification and bus handshake; a store wins over MEM_TO_REG
    always_comb begin
        is_store    = execute_datamem_wr_enable;
        is_load     = (execute_result_src == MEM_TO_REG) && !execute_datamem_wr_enable;
        is_mem      = is_store || is_load;
        aligned_op  = is_mem && !misaligned;
        timeout_hit = (state == WAIT) && (counter == TIMEOUT_CNT);
        // The request is withdrawn in the abort cycle, so a coincident ack is ignored
        dmem_req    = !rst && (((state == IDLE) && aligned_op) ||
                               ((state == WAIT) && !timeout_hit));
        acked       = dmem_req && dmem_ack;
        mem_stall   = dmem_req && !dmem_ack;
        dmem_we     = is_store;
        dmem_addr   = {execute_alu_result[ADDR_W-1:2], 2'b00};
        dmem_be     = lane_be;
        dmem_wdata  = lane_wdata;
    end

    // Access FSM, timeout counter and the registered mem_* outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            counter               <= '0;
            mem_rd                <= '0;
            mem_regfile_wr_enable <= 1'b0;
            mem_result_src        <= '0;
            mem_alu_result        <= '0;
            mem_read_data         <= '0;
            mem_instr_addr_plus   <= '0;
            mem_misaligned        <= 1'b0;
            mem_bus_error         <= 1'b0;
        end else begin
            mem_rd              <= execute_rd;
            mem_result_src      <= execute_result_src;
            mem_alu_result      <= execute_alu_result;
            mem_instr_addr_plus <= execute_instr_addr_plus;
            mem_read_data       <= (is_load && acked) ? load_ext : 32'h0;
            mem_misaligned      <= 1'b0;
            mem_bus_error       <= 1'b0;
            case (state)
                IDLE: begin
                    if (aligned_op && !dmem_ack) begin
                        state                 <= WAIT;
                        counter               <= 16'd1;
                        mem_regfile_wr_enable <= 1'b0;
                    end else begin
                        mem_regfile_wr_enable <= execute_regfile_wr_enable &&
                                                 !(is_mem && misaligned);
                        mem_misaligned        <= is_mem && misaligned;
                    end
                end
                WAIT: begin
                    if (acked) begin
                        state                 <= IDLE;
                        counter               <= '0;
                        mem_regfile_wr_enable <= execute_regfile_wr_enable;
                    end else if (timeout_hit) begin
                        state                 <= IDLE;
                        counter               <= '0;
                        mem_regfile_wr_enable <= 1'b0;
                        mem_bus_error         <= 1'b1;
                    end else begin
                        counter               <= counter + 16'd1;
                        mem_regfile_wr_enable <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    counter <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_memory.sv
// Scoreboard bench for stage_memory: each operation pushes its expected
// writeback record when driven and pops/compares it when the stage retires it.
module tb_stage_memory;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] data;
        logic [2:0]  f3;
        logic        we;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] ipc;
    } op_t;

    typedef struct {
        logic [4:0]  rd;
        logic        wen;
        logic [1:0]  rsrc;
        logic [31:0] alu;
        logic [31:0] ipc;
        logic [31:0] rdata;
        logic        mis;
        logic        berr;
        logic        chk_rd;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] execute_alu_result;
    logic [31:0] execute_wr_datamem_data;
    logic [2:0]  execute_funct3;
    logic        execute_datamem_wr_enable;
    logic [1:0]  execute_result_src;
    logic [4:0]  execute_rd;
    logic        execute_regfile_wr_enable;
    logic [31:0] execute_instr_addr_plus;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic [4:0]  mem_rd;
    logic        mem_regfile_wr_enable;
    logic [1:0]  mem_result_src;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_read_data;
    logic [31:0] mem_instr_addr_plus;
    logic        mem_misaligned;
    logic        mem_bus_error;

    int n_cmp = 0;
    int n_err = 0;
    exp_t sb_q[$];

    stage_memory #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .execute_alu_result        (execute_alu_result),
        .execute_wr_datamem_data   (execute_wr_datamem_data),
        .execute_funct3            (execute_funct3),
        .execute_datamem_wr_enable (execute_datamem_wr_enable),
        .execute_result_src        (execute_result_src),
        .execute_rd                (execute_rd),
        .execute_regfile_wr_enable (execute_regfile_wr_enable),
        .execute_instr_addr_plus   (execute_instr_addr_plus),
        .mem_stall                 (mem_stall),
        .dmem_req                  (dmem_req),
        .dmem_we                   (dmem_we),
        .dmem_addr                 (dmem_addr),
        .dmem_be                   (dmem_be),
        .dmem_wdata                (dmem_wdata),
        .dmem_rdata                (dmem_rdata),
        .dmem_ack                  (dmem_ack),
        .mem_rd                    (mem_rd),
        .mem_regfile_wr_enable     (mem_regfile_wr_enable),
        .mem_result_src            (mem_result_src),
        .mem_alu_result            (mem_alu_result),
        .mem_read_data             (mem_read_data),
        .mem_instr_addr_plus       (mem_instr_addr_plus),
        .mem_misaligned            (mem_misaligned),
        .mem_bus_error             (mem_bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input op_t op);
        execute_alu_result        = op.alu;
        execute_wr_datamem_data   = op.data;
        execute_funct3            = op.f3;
        execute_datamem_wr_enable = op.we;
        execute_result_src        = op.rs;
        execute_rd                = op.rd;
        execute_regfile_wr_enable = op.wen;
        execute_instr_addr_plus   = op.ipc;
    endtask

    task automatic drive_nop();
        op_t n;
        n = '{alu: 32'h0, data: 32'h0, f3: 3'b000, we: 1'b0, rs: 2'b00,
              rd: 5'd0, wen: 1'b0, ipc: 32'h0};
        drive(n);
    endtask

    // Called just after a rising edge. ack_wait < 0 means the bus never acks.
    task automatic do_op(input string tag, input op_t op, input int ack_wait,
                         input logic [31:0] rdata, input exp_t e, input int exp_stall,
                         input logic exp_req_done, input logic chk_bus,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata);
        int   stalls;
        int   waited;
        logic done;
        exp_t got;
        stalls = 0;
        waited = 0;
        done   = 1'b0;
        drive(op);
        dmem_rdata = rdata;
        dmem_ack   = (ack_wait == 0);
        sb_q.push_back(e);
        @(negedge clk);
        if (chk_bus) begin
            check({tag, "_req"}, 32'(dmem_req), 32'd1);
            check({tag, "_addr"}, dmem_addr, exp_addr);
            check({tag, "_be"}, 32'(dmem_be), 32'(exp_be));
            check({tag, "_we"}, 32'(dmem_we), 32'(op.we));
            if (op.we) check({tag, "_wdata"}, dmem_wdata, exp_wdata);
        end else begin
            check({tag, "_noreq"}, 32'(dmem_req), 32'd0);
        end
        for (int i = 0; i < 64; i++) begin
            if (i != 0) @(negedge clk);
            if (!mem_stall) begin
                check({tag, "_req_done"}, 32'(dmem_req), 32'(exp_req_done));
                @(posedge clk);
                #1;
                done = 1'b1;
                break;
            end
            stalls++;
            @(posedge clk);
            #1;
            check({tag, "_bubble"}, 32'(mem_regfile_wr_enable), 32'd0);
            waited++;
            dmem_ack = (ack_wait >= 0) && (waited == ack_wait);
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_stalls"}, 32'(stalls), 32'(exp_stall));
        got = sb_q.pop_front();
        check({tag, "_rd"}, 32'(mem_rd), 32'(got.rd));
        check({tag, "_wen"}, 32'(mem_regfile_wr_enable), 32'(got.wen));
        check({tag, "_rsrc"}, 32'(mem_result_src), 32'(got.rsrc));
        check({tag, "_alu"}, mem_alu_result, got.alu);
        check({tag, "_ipc"}, mem_instr_addr_plus, got.ipc);
        check({tag, "_mis"}, 32'(mem_misaligned), 32'(got.mis));
        check({tag, "_berr"}, 32'(mem_bus_error), 32'(got.berr));
        if (got.chk_rd) check({tag, "_rdata"}, mem_read_data, got.rdata);
        dmem_ack = 1'b0;
        drive_nop();
    endtask

    op_t  op;
    exp_t e;

    initial begin
        rst = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        drive_nop();
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd", 32'(mem_rd), 32'd0);
        check("rst_wen", 32'(mem_regfile_wr_enable), 32'd0);
        check("rst_alu", mem_alu_result, 32'h0);
        check("rst_rdata", mem_read_data, 32'h0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_stall", 32'(mem_stall), 32'd0);
        rst = 1'b0;

        // ALU op: single-cycle pass-through, no bus traffic
        op = '{alu: 32'h1234, data: 32'h0, f3: 3'b010, we: 1'b0, rs: 2'b00, rd: 5'd5, wen: 1'b1, ipc: 32'h1004};
        e  = '{rd: 5'd5, wen: 1'b1, rsrc: 2'b00, alu: 32'h1234, ipc: 32'h1004, rdata: 32'h0, mis: 1'b0, berr: 1'b0, chk_rd: 1'b0};
        do_op("alu", op, 0, 32'h0, e, 0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

        // SB to lane 3, zero-wait ack
        op = '{alu: 32'h103, data: 32'hAABBCCDD, f3: 3'b000, we: 1'b1, rs: 2'b00, rd: 5'd0, wen: 1'b0, ipc: 32'h1008};
        e  = '{rd: 5'd0, wen: 1'b0, rsrc: 2'b00, alu: 32'h103, ipc: 32'h1008, rdata: 32'h0, mis: 1'b0, berr: 1'b0, chk_rd: 1'b0};
        do_op("sb", op, 0, 32'h0, e, 0, 1'b1, 1'b1, 32'h100, 4'b1000, 32'hDDDDDDDD);

        // SH to upper half, one wait cycle
        op = '{alu: 32'h102, data: 32'h1234ABCD, f3: 3'b001, we: 1'b1, rs: 2'b00, rd: 5'd0, wen: 1'b0, ipc: 32'h100C};
        e  = '{rd: 5'd0, wen: 1'b0, rsrc: 2'b00, alu: 32'h102, ipc: 32'h100C, rdata: 32'h0, mis: 1'b0, berr: 1'b0, chk_rd: 1'b0};
        do_op("sh", op, 1, 32'h0, e, 1, 1'b1, 1'b1, 32'h100, 4'b1100, 32'hABCDABCD);

        // LB / LBU with three wait cycles
        op = '{alu: 32'h101, data: 32'h0, f3: 3'b000, we: 1'b0, rs: 2'b01, rd: 5'd7, wen: 1'b1, ipc: 32'h1010};
        e  = '{rd: 5'd7, wen: 1'b1, rsrc: 2'b01, alu: 32'h101, ipc: 32'h1010, rdata: 32'hFFFFFF80, mis: 1'b0, berr: 1'b0, chk_rd: 1'b1};
        do_op("lb", op, 3, 32'h00008000, e, 3, 1'b1, 1'b1, 32'h100, 4'b0010, 32'h0);
        op.f3 = 3'b100;
        e.rdata = 32'h00000080;
        do_op("lbu", op, 3, 32'h00008000, e, 3, 1'b1, 1'b1, 32'h100, 4'b0010, 32'h0);

        // LH / LHU upper half, zero-wait
        op = '{alu: 32'h202, data: 32'h0, f3: 3'b001, we: 1'b0, rs: 2'b01, rd: 5'd8, wen: 1'b1, ipc: 32'h1014};
        e  = '{rd: 5'd8, wen: 1'b1, rsrc: 2'b01, alu: 32'h202, ipc: 32'h1014, rdata: 32'hFFFF8001, mis: 1'b0, berr: 1'b0, chk_rd: 1'b1};
        do_op("lh", op, 0, 32'h80011234, e, 0, 1'b1, 1'b1, 32'h200, 4'b1100, 32'h0);
        op.f3 = 3'b101;
        e.rdata = 32'h00008001;
        do_op("lhu", op, 0, 32'h80011234, e, 0, 1'b1, 1'b1, 32'h200, 4'b1100, 32'h0);

        // LW misaligned: no request, one-cycle flag, write suppressed
        op = '{alu: 32'h102, data: 32'h0, f3: 3'b010, we: 1'b0, rs: 2'b01, rd: 5'd9, wen: 1'b1, ipc: 32'h1018};
        e  = '{rd: 5'd9, wen: 1'b0, rsrc: 2'b01, alu: 32'h102, ipc: 32'h1018, rdata: 32'h0, mis: 1'b1, berr: 1'b0, chk_rd: 1'b0};
        do_op("lw_mis", op, 0, 32'h0, e, 0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(posedge clk);
        #1;
        check("mis_pulse_end", 32'(mem_misaligned), 32'd0);

        // LW that never gets an ack: timeout after 4 stalled cycles
        op = '{alu: 32'h300, data: 32'h0, f3: 3'b010, we: 1'b0, rs: 2'b01, rd: 5'd10, wen: 1'b1, ipc: 32'h101C};
        e  = '{rd: 5'd10, wen: 1'b0, rsrc: 2'b01, alu: 32'h300, ipc: 32'h101C, rdata: 32'h0, mis: 1'b0, berr: 1'b1, chk_rd: 1'b0};
        do_op("lw_to", op, -1, 32'hDEADBEEF, e, 4, 1'b0, 1'b1, 32'h300, 4'b1111, 32'h0);
        @(posedge clk);
        #1;
        dmem_ack = 1'b1;
        @(negedge clk);
        check("late_ack_req", 32'(dmem_req), 32'd0);
        check("late_ack_stall", 32'(mem_stall), 32'd0);
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        check("late_ack_berr", 32'(mem_bus_error), 32'd0);
        check("late_ack_wen", 32'(mem_regfile_wr_enable), 32'd0);

        // Reset while waiting on a load drops the access
        op = '{alu: 32'h400, data: 32'h0, f3: 3'b000, we: 1'b0, rs: 2'b01, rd: 5'd11, wen: 1'b1, ipc: 32'h1020};
        drive(op);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("wait_stall", 32'(mem_stall), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstw_req", 32'(dmem_req), 32'd0);
        check("rstw_stall", 32'(mem_stall), 32'd0);
        check("rstw_rd", 32'(mem_rd), 32'd0);
        check("rstw_alu", mem_alu_result, 32'h0);
        check("rstw_ipc", mem_instr_addr_plus, 32'h0);
        check("rstw_rsrc", 32'(mem_result_src), 32'd0);
        rst = 1'b0;
        drive_nop();

        // LH after reset: lower half of 0x7FFF0000 is zero
        op = '{alu: 32'h200, data: 32'h0, f3: 3'b001, we: 1'b0, rs: 2'b01, rd: 5'd12, wen: 1'b1, ipc: 32'h1024};
        e  = '{rd: 5'd12, wen: 1'b1, rsrc: 2'b01, alu: 32'h200, ipc: 32'h1024, rdata: 32'h0, mis: 1'b0, berr: 1'b0, chk_rd: 1'b1};
        do_op("lh_post", op, 0, 32'h7FFF0000, e, 0, 1'b1, 1'b1, 32'h200, 4'b0011, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stage_memory.md
Name: stage_memory

Overview:
- Pipeline stage directly downstream of the execute stage; sits between execute and writeback.
- Issues loads/stores to data memory over a req/ack bus, including byte/halfword/word lane steering and load sign/zero extension.
- Stalls upstream while a bus access is outstanding, flags misaligned accesses and bus timeouts.
- Registers the mem_* forwarding/writeback signals consumed by the execute and writeback stages.

Parameters:
- TIMEOUT_CYCLES, 255: WAIT cycles without ack before the access is aborted. Legal range 2..65535.
- ADDR_W, 32: data bus address width; low ADDR_W bits of execute_alu_result are used.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- execute_alu_result  in  32  ALU result; effective address for loads/stores
- execute_wr_datamem_data  in  32  store data, rs2 after forwarding
- execute_funct3  in  3  access size/sign
- execute_datamem_wr_enable  in  1  store
- execute_result_src  in  2  00 ALU, 01 MEM_TO_REG (load), 10 PC_PLUS, 11 LUI_AUIPC
- execute_rd  in  5  destination register
- execute_regfile_wr_enable  in  1  regfile write request
- execute_instr_addr_plus  in  32  PC+4
- mem_stall  out  1  combinational; upstream stages hold while high
- dmem_req  out  1  bus request
- dmem_we  out  1  write
- dmem_addr  out  ADDR_W  word-aligned address, low 2 bits forced to 0
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-steered store data
- dmem_rdata  in  32  read word
- dmem_ack  in  1  access complete; may arrive in the same cycle as dmem_req
- mem_rd  out  5  registered rd
- mem_regfile_wr_enable  out  1  registered, gated
- mem_result_src  out  2  registered
- mem_alu_result  out  32  registered
- mem_read_data  out  32  registered, extended load data
- mem_instr_addr_plus  out  32  registered
- mem_misaligned  out  1  one-cycle pulse
- mem_bus_error  out  1  one-cycle pulse on timeout

Behaviour:
- Reset: every registered output is 0, state is IDLE, the counter is 0, dmem_req is 0.
- Access classification:
  - store = execute_datamem_wr_enable.
  - load = (result_src == 01) && !store. If both are set, the access is treated as a store.
  - Anything else is a non-memory op.
- Non-memory op: no bus activity, mem_stall is 0, all mem_* outputs capture their inputs the next edge. Latency is 1.
- Alignment check:
  - funct3[1:0] = 00 (byte): always aligned.
  - 01 (half): requires addr[0] = 0.
  - 10 (word): requires addr[1:0] = 0.
  - 11: treated as word.
- Misaligned access:
  - No request is issued and there is no stall.
  - Next edge: mem_misaligned = 1 and mem_regfile_wr_enable = 0; the other mem_* outputs capture normally.
- Store lanes:
  - SB: be = 0001 << addr[1:0]; wdata = byte replicated x4.
  - SH: be = 0011 << addr[1:0]; wdata = half replicated x2.
  - SW: be = 1111.
- Load lanes:
  - Loads drive be the same way as stores, with dmem_we = 0.
  - mem_read_data = rdata >> (8 * addr[1:0]), then extended.
  - funct3 000 LB sign-extend, 100 LBU zero-extend, 001 LH sign-extend, 101 LHU zero-extend, 010 LW as-is.
- FSM states: IDLE, WAIT.
- IDLE with an aligned memory op:
  - dmem_req = 1 combinationally, with addr/be/wdata/we derived from the current inputs.
  - If dmem_ack is 1: complete this edge, mem_stall = 0 (zero-wait access, latency 1).
  - Else: mem_stall = 1, go to WAIT, counter = 1, and register mem_regfile_wr_enable = 0 (bubble).
- WAIT:
  - dmem_req stays 1 and the bus fields are driven from the held execute_* inputs; upstream keeps them stable because mem_stall is high.
  - On dmem_ack: complete, mem_stall = 0, go to IDLE.
  - Else, if counter == TIMEOUT_CYCLES: mem_stall = 0, dmem_req = 0, abort. Next edge: mem_bus_error = 1 and mem_regfile_wr_enable = 0; go to IDLE.
  - Else: counter++ and the bubble is kept.
- Completion edge:
  - All mem_* outputs capture their inputs.
  - For loads, mem_read_data captures the extended dmem_rdata.
  - mem_regfile_wr_enable = execute_regfile_wr_enable.
- dmem_ack while dmem_req = 0 (late ack after an abort or reset) is ignored.
- rst asserted during WAIT: next edge returns to IDLE with all outputs 0. The access is dropped and not retried.
- mem_stall depends combinationally only on the inputs and state; it never depends on dmem_rdata.

Decomposition:
- core_pkg holds:
  - result_src constants ALU_RESULT / MEM_TO_REG / PC_PLUS / LUI_AUIPC
  - funct3 size encodings LS_B / LS_H / LS_W / LS_BU / LS_HU
  - the mem_state_t enum {IDLE, WAIT}
- One sub-module, lsu_align (combinational):
  - inputs: addr[1:0], funct3, store data, rdata
  - outputs: be, wdata, extended load data, misaligned
- stage_memory keeps the FSM, timeout counter and pipeline registers.

Test Plan:
1. ALU op, alu_result=0x1234, rd=5, wr_en=1 -> next edge mem_alu_result=0x1234, mem_rd=5, mem_regfile_wr_enable=1; dmem_req never asserted.
2. SB addr=0x103, data=0xAABBCCDD, ack same cycle -> be=1000, wdata=0xDDDDDDDD, addr=0x100, no stall.
3. LB addr=0x101, rdata=0x00008000 with ack after 3 cycles -> mem_stall high for 3 cycles with bubbles, then mem_read_data=0xFFFFFF80; same stimulus as LBU -> 0x00000080.
4. LW addr=0x102 -> no dmem_req, mem_misaligned pulses 1 cycle, mem_regfile_wr_enable=0.
5. LW with ack never asserted, TIMEOUT_CYCLES=4 -> stall for 4 cycles, then mem_bus_error pulse, dmem_req drops, wr_en=0; an ack injected 2 cycles later has no effect.
6. rst pulsed in WAIT -> next edge dmem_req=0, mem_stall=0, all outputs 0; the following LH addr=0x200 with rdata=0x7FFF0000 and ack -> mem_read_data=0x00000000.
